forward_scoreboard: RTL

Parametrised data-hazard unit for the pipelined RV32I core. It supersedes the purely combinational opcode-based rd-write detection with a registered scoreboard of in-flight destinations. For the instruction in ID it decides between forwarding and a load-use stall, and hands EX a registered forward-source select per source operand. It sits beside the ID/EX pipeline register and advances with it.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/fwd_match.sv | 45 ++++
 rtl/forward_scoreboard.sv | 103 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the pipelined core.
// Holds the opcode enum, the hazard scoreboard entry and the rd-write predicate.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // Opcode 0 is a bubble; branches, stores and CSR ops never produce an rd value here.
  function automatic logic writes_rd(rv32i_opcode op);
    return (op != rv32i_opcode'(7'd0)) && (op != op_br) && (op != op_store) && (op != op_csr);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority match over the scoreboard slots.
// Ports:
//   rs_i        source register index
//   used_i      operand is actually read
//   slots_i     scoreboard, slot 1 (youngest) .. NUM_STAGES (oldest)
//   sel_o       forward source once the consumer is in EX (0 = register file)
//   not_ready_o youngest producer cannot be forwarded yet
module fwd_match
  import rv32i_types::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ALU_READY  = 2,
  parameter int unsigned LOAD_READY = 3,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [4:0]                  rs_i,
  input  logic                        used_i,
  input  sb_entry_t [NUM_STAGES:1]    slots_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        not_ready_o
);

  logic found;

  always_comb begin
    sel_o       = '0;
    not_ready_o = 1'b0;
    found       = 1'b0;
    for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
      // valid already folds in writes_rd; rs != 0 excludes rd == x0.
      if (!found && used_i && (rs_i != 5'd0) && slots_i[k].valid && (slots_i[k].rd == rs_i)) begin
        found = 1'b1;
        // Producer will be one slot further on when the consumer reaches EX.
        if (k + 1 > NUM_STAGES) begin
          sel_o = '0;  // already written back, write-first register file
        end else if (k + 1 >= (slots_i[k].is_load ? LOAD_READY : ALU_READY)) begin
          sel_o = SEL_W'(k + 1);
        end else begin
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Registered data-hazard scoreboard beside the ID/EX register.
// Tracks in-flight destinations, raises a load-use stall for the ID instruction and
// hands EX a registered per-operand forward select.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   advance        pipeline registers load this cycle
//   flush          squash ID/EX slot and ID instruction
//   id_opcode/rd   ID instruction opcode (0 = bubble) and destination
//   id_rs/rs_used  packed source indices (operand 0 in LSBs) and read flags
//   stall          load-use stall (combinational)
//   ex_fwd_sel     per-operand forward source for the instruction in EX
//   stall_count    saturating count of inserted load-use bubbles
module forward_scoreboard
  import rv32i_types::*;
#(
  parameter  int unsigned NUM_STAGES = 3,
  parameter  int unsigned NUM_SRC    = 2,
  parameter  int unsigned ALU_READY  = 2,
  parameter  int unsigned LOAD_READY = 3,
  localparam int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance,
  input  logic                       flush,
  input  logic [6:0]                 id_opcode,
  input  logic [4:0]                 id_rd,
  input  logic [NUM_SRC*5-1:0]       id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [15:0]                stall_count
);

  sb_entry_t [NUM_STAGES:1]   slots_q, slots_d;
  logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_d, sel_c;
  logic [NUM_SRC-1:0]         not_ready;
  logic [15:0]                cnt_q, cnt_d;
  sb_entry_t                  id_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .NUM_STAGES (NUM_STAGES),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY),
      .SEL_W      (SEL_W)
    ) u_match (
      .rs_i        (id_rs[i*5 +: 5]),
      .used_i      (id_rs_used[i]),
      .slots_i     (slots_q),
      .sel_o       (sel_c[i*SEL_W +: SEL_W]),
      .not_ready_o (not_ready[i])
    );
  end

  always_comb begin
    id_entry.valid   = writes_rd(rv32i_opcode'(id_opcode));
    id_entry.rd      = id_rd;
    id_entry.is_load = (id_opcode == op_load);
  end

  assign stall = (|not_ready) & ~flush;

  always_comb begin
    slots_d = slots_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (advance) begin
      for (int k = NUM_STAGES; k >= 2; k--) begin
        slots_d[k] = slots_q[k-1];
      end
    end
    if (flush) begin
      slots_d[1] = '0;
      sel_d      = '0;
    end else if (advance) begin
      if (stall) begin
        slots_d[1] = '0;
        sel_d      = '0;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else begin
        slots_d[1] = id_entry;
        sel_d      = sel_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_fwd_sel  = sel_q;
  assign stall_count = cnt_q;

endmodule
